// File: rtl/mem_stage_ctrl.sv
// MEM stage: owns the data-memory array, one load/store per handshake, lane select + extension,
// registered response after WAIT_STATES stalls. Optional macro MEM_MISALIGN_TRAP_EN traps misaligned half/word.
module mem_stage_ctrl #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [1:0]  mem_length,
    input  logic        mem_signed,
    input  logic [31:0] address,
    input  logic [31:0] mem_write_data,
    output logic        resp_valid,
    output logic [31:0] mem_read_data,
    output logic        misalign
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS
    } state_t;

    state_t state, state_next;

    logic [2:0]    wait_count;
    logic          accept;
    logic          lat_read;
    logic          lat_write;
    logic [1:0]    lat_length;
    logic          lat_signed;
    logic [AW+1:0] lat_addr;
    logic [31:0]   lat_wdata;

    logic [31:0]   mem [DEPTH];

    logic          is_byte;
    logic          is_half;
    logic          is_word;
    logic          trap;
    logic [1:0]    byte_off;
    logic [AW-1:0] word_idx;
    logic [31:0]   old_word;
    logic [3:0]    byte_en;
    logic [31:0]   shifted_wdata;
    logic [31:0]   new_word;
    logic [31:0]   aligned;
    logic [31:0]   load_value;
    logic [31:0]   read_result;

    // Address bits above the array are deliberately ignored so accesses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^address[31:AW+2];

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (accept) state_next = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
            S_WAIT:   if (wait_count == 3'd0) state_next = S_ACCESS;
            S_ACCESS: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_count <= 3'd0;
        end else if (accept) begin
            wait_count <= WAIT_LOAD;
        end else if (state == S_WAIT && wait_count != 3'd0) begin
            wait_count <= wait_count - 3'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lat_read   <= 1'b0;
            lat_write  <= 1'b0;
            lat_length <= 2'b00;
            lat_signed <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= 32'd0;
        end else if (accept) begin
            lat_read   <= memread;
            lat_write  <= memwrite;
            lat_length <= mem_length;
            lat_signed <= mem_signed;
            lat_addr   <= address[AW+1:0];
            lat_wdata  <= mem_write_data;
        end
    end

    assign is_byte  = (lat_length == 2'b00);
    assign is_half  = (lat_length == 2'b01);
    assign is_word  = lat_length[1];
    assign word_idx = lat_addr[AW+1:2];
    assign old_word = mem[word_idx];

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = (is_half && lat_addr[0]) || (is_word && (lat_addr[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    // Without the trap, offending low bits are simply dropped by this offset selection.
    always_comb begin
        byte_off = 2'b00;
        byte_en  = 4'b1111;
        if (is_byte) begin
            byte_off = lat_addr[1:0];
            byte_en  = 4'b0001 << lat_addr[1:0];
        end else if (is_half) begin
            byte_off = {lat_addr[1], 1'b0};
            byte_en  = lat_addr[1] ? 4'b1100 : 4'b0011;
        end
    end

    assign shifted_wdata = lat_wdata << {byte_off, 3'b000};
    assign aligned       = old_word >> {byte_off, 3'b000};

    always_comb begin
        new_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) new_word[8*i +: 8] = shifted_wdata[8*i +: 8];
        end
    end

    always_comb begin
        load_value = aligned;
        if (is_byte) begin
            load_value = {{24{lat_signed & aligned[7]}}, aligned[7:0]};
        end else if (is_half) begin
            load_value = {{16{lat_signed & aligned[15]}}, aligned[15:0]};
        end
    end

    assign read_result = (lat_read && !trap) ? load_value : 32'd0;

    // old_word is sampled before this edge, giving read-before-write when both are set.
    always_ff @(posedge clock) begin
        if (state == S_ACCESS && lat_write && !trap) begin
            mem[word_idx] <= new_word;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            resp_valid    <= 1'b0;
            mem_read_data <= 32'd0;
            misalign      <= 1'b0;
        end else begin
            resp_valid <= (state == S_ACCESS);
            if (state == S_ACCESS) begin
                mem_read_data <= read_result;
                misalign      <= trap;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed cases plus random traffic against a byte-level model.
// Honours MEM_MISALIGN_TRAP_EN the same way the design does.
module tb_mem_stage_ctrl;

    localparam int WS    = 3;
    localparam int DEPTH = 1024;
    localparam int BYTES = 4 * DEPTH;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        memread;
    logic        memwrite;
    logic [1:0]  mem_length;
    logic        mem_signed;
    logic [31:0] address;
    logic [31:0] mem_write_data;
    logic        resp_valid;
    logic [31:0] mem_read_data;
    logic        misalign;

    int          checks;
    int          failures;
    logic [31:0] last_data;
    logic [7:0]  mb [BYTES];

    mem_stage_ctrl #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .memread        (memread),
        .memwrite       (memwrite),
        .mem_length     (mem_length),
        .mem_signed     (mem_signed),
        .address        (address),
        .mem_write_data (mem_write_data),
        .resp_valid     (resp_valid),
        .mem_read_data  (mem_read_data),
        .misalign       (misalign)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Memory viewed as a flat little-endian byte array; addresses wrap at the array size.
    function automatic void model_access(input logic rd, input logic wr, input logic [1:0] len,
                                         input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                                         output logic [31:0] exp_data, output logic exp_mis);
        int size;
        int off;
        int base;
        longint val;
        size     = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
        off      = int'(addr % BYTES);
        exp_data = 32'd0;
        exp_mis  = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        if (off % size != 0) begin
            exp_mis = 1'b1;
            return;
        end
`endif
        base = off - (off % size);
        val  = 0;
        for (int i = 0; i < size; i++) val += longint'(mb[base + i]) << (8 * i);
        if (sgn && size < 4 && val >= (longint'(1) << (8 * size - 1))) val -= longint'(1) << (8 * size);
        if (rd) exp_data = val[31:0];
        if (wr) begin
            for (int i = 0; i < size; i++) mb[base + i] = wdata[8*i +: 8];
        end
    endfunction

    task automatic apply_stimulus(input logic rd, input logic wr, input logic [1:0] len, input logic sgn,
                                  input logic [31:0] addr, input logic [31:0] wdata, output logic [31:0] got);
        logic [31:0] exp_data;
        logic        exp_mis;
        for (int n = 0; n < 20 && req_ready !== 1'b1; n++) @(negedge clock);
        check_output("ready_before_req", 32'(req_ready), 32'd1);
        model_access(rd, wr, len, sgn, addr, wdata, exp_data, exp_mis);
        memread        = rd;
        memwrite       = wr;
        mem_length     = len;
        mem_signed     = sgn;
        address        = addr;
        mem_write_data = wdata;
        req_valid      = 1'b1;
        @(posedge clock);
        for (int k = 1; k <= 2 + WS; k++) begin
            @(negedge clock);
            if (k < 2 + WS) begin
                check_output("busy_ready", 32'(req_ready), 32'd0);
                check_output("early_resp", 32'(resp_valid), 32'd0);
                check_output("data_hold", mem_read_data, last_data);
                req_valid      = 1'($urandom);
                memread        = 1'($urandom);
                memwrite       = 1'($urandom);
                mem_length     = 2'($urandom);
                address        = $urandom;
                mem_write_data = $urandom;
            end else begin
                check_output("resp_valid", 32'(resp_valid), 32'd1);
                check_output("resp_ready", 32'(req_ready), 32'd1);
                check_output("read_data", mem_read_data, exp_data);
                check_output("misalign", 32'(misalign), 32'(exp_mis));
                req_valid = 1'b0;
            end
        end
        got       = mem_read_data;
        last_data = exp_data;
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] hi;
        checks         = 0;
        failures       = 0;
        last_data      = 32'd0;
        reset          = 1'b0;
        req_valid      = 1'b0;
        memread        = 1'b0;
        memwrite       = 1'b0;
        mem_length     = 2'b00;
        mem_signed     = 1'b0;
        address        = 32'd0;
        mem_write_data = 32'd0;

        repeat (2) @(negedge clock);
        check_output("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_output("rst_data", mem_read_data, 32'd0);
        check_output("rst_misalign", 32'(misalign), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        check_output("rst_ready", 32'(req_ready), 32'd1);

        // Give the exercised region (words 0..15) known contents.
        for (int i = 0; i < 16; i++) begin
            hi = $urandom & 32'hFFFF_F000;
            apply_stimulus(1'b0, 1'b1, 2'b10, 1'b0, hi | 32'(i * 4), $urandom & 32'h7FFF_FFFF, got);
        end

        apply_stimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, got);
        apply_stimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got);
        check_output("t1_word", got, 32'hDEADBEEF);

        apply_stimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h12345680, got);
        apply_stimulus(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, got);
        check_output("t2_byte_s", got, 32'hFFFFFF80);
        apply_stimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, got);
        check_output("t2_byte_u", got, 32'h00000080);
        apply_stimulus(1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, got);
        check_output("t2_half_s", got, 32'hFFFF80AD);
        apply_stimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got);
        check_output("t2_word", got, 32'h80ADBEEF);

        apply_stimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h11, 32'h0, got);
`ifdef MEM_MISALIGN_TRAP_EN
        check_output("t4_misalign", got, 32'h0);
`else
        check_output("t4_forced", got, 32'h80ADBEEF);
`endif
        apply_stimulus(1'b0, 1'b1, 2'b11, 1'b0, 32'h12, 32'hCAFEF00D, got);
        apply_stimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got);

        apply_stimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h1000, 32'h12345678, got);
        apply_stimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000, 32'h0, got);
        check_output("t5_wrap", got, 32'h12345678);

        apply_stimulus(1'b1, 1'b1, 2'b01, 1'b0, 32'h12, 32'h00005555, got);
        apply_stimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got);
        apply_stimulus(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'hFFFFFFFF, got);
        check_output("neither_zero", got, 32'h0);

        // Reset during WAIT must drop the store and produce no response.
        memread        = 1'b0;
        memwrite       = 1'b1;
        mem_length     = 2'b10;
        mem_signed     = 1'b0;
        address        = 32'h20;
        mem_write_data = 32'hFFFFFFFF;
        req_valid      = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        reset     = 1'b0;
        #1;
        check_output("t6_rst_resp", 32'(resp_valid), 32'd0);
        check_output("t6_rst_data", mem_read_data, 32'd0);
        check_output("t6_rst_mis", 32'(misalign), 32'd0);
        @(negedge clock);
        reset     = 1'b1;
        last_data = 32'd0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clock);
            check_output("t6_no_resp", 32'(resp_valid), 32'd0);
            check_output("t6_ready", 32'(req_ready), 32'd1);
        end
        apply_stimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, got);

        for (int n = 0; n < 150; n++) begin
            hi = $urandom & 32'hFFFF_F000;
            apply_stimulus(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                           hi | 32'($urandom_range(0, 63)), $urandom, got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
